// File: rtl/dm_copy_engine.sv
// Block-command engine that masters the 8-bit data memory: copy, fill or byte-sum over a
// pointer range. Memory-side outputs are decoded from the registered state and pointers only.
module dm_copy_engine #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          Start,
    input  logic [1:0]    Op,
    input  logic [AW-1:0] SrcAdr,
    input  logic [AW-1:0] DstAdr,
    input  logic [AW:0]   Len,
    input  logic [7:0]    FillVal,
    output logic          Busy,
    output logic          Done,
    output logic          Err,
    output logic [7:0]    Result,
    output logic [AW-1:0] MemAdr,
    output logic          ReadEn,
    output logic          WriteEn,
    output logic [7:0]    DatIn,
    input  logic [7:0]    DatOut
);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    localparam logic [1:0]    OP_COPY = 2'b00;
    localparam logic [1:0]    OP_FILL = 2'b01;
    localparam logic [1:0]    OP_SUM  = 2'b10;
    localparam logic [1:0]    OP_ILL  = 2'b11;
    localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};

    state_t        state;
    logic [AW-1:0] src_ptr;
    logic [AW-1:0] dst_ptr;
    logic [AW:0]   cnt;
    logic [7:0]    data_reg;
    logic [7:0]    fill_val;
    logic [7:0]    acc;
    logic [1:0]    op;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            src_ptr  <= '0;
            dst_ptr  <= '0;
            cnt      <= '0;
            data_reg <= '0;
            fill_val <= '0;
            acc      <= '0;
            op       <= OP_COPY;
            Result   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        src_ptr  <= SrcAdr;
                        dst_ptr  <= DstAdr;
                        cnt      <= Len;
                        fill_val <= FillVal;
                        op       <= Op;
                        if (Op == OP_SUM) acc <= '0;
                        if (Op == OP_ILL || Len == '0) state <= DONE;
                        else if (Op == OP_FILL)         state <= WR;
                        else                            state <= RD;
                    end
                end
                RD: begin
                    src_ptr <= src_ptr + PTR_ONE;
                    if (op == OP_COPY) begin
                        data_reg <= DatOut;
                        state    <= WR;
                    end else begin
                        acc   <= acc + DatOut;
                        cnt   <= cnt - CNT_ONE;
                        state <= (cnt == CNT_ONE) ? DONE : RD;
                    end
                end
                WR: begin
                    dst_ptr <= dst_ptr + PTR_ONE;
                    cnt     <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE)     state <= DONE;
                    else if (op == OP_COPY) state <= RD;
                    else                    state <= WR;
                end
                DONE: begin
                    if (op == OP_SUM) Result <= acc;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign Busy = (state != IDLE);
    assign Done = (state == DONE);
    assign Err  = (state == DONE) && (op == OP_ILL);

    // Read and write enables come from disjoint states, so they can never overlap.
    always_comb begin
        MemAdr  = '0;
        ReadEn  = 1'b0;
        WriteEn = 1'b0;
        DatIn   = '0;
        case (state)
            RD: begin
                MemAdr = src_ptr;
                ReadEn = 1'b1;
            end
            WR: begin
                MemAdr  = dst_ptr;
                WriteEn = 1'b1;
                DatIn   = (op == OP_FILL) ? fill_val : data_reg;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dm_copy_engine.sv
// Bench for dm_copy_engine: behavioural byte memory, reference memory model and a write
// scoreboard of expected {address, data} pairs checked as the engine issues writes.
module tb_dm_copy_engine;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          Start = 1'b0;
    logic [1:0]    Op = '0;
    logic [AW-1:0] SrcAdr = '0;
    logic [AW-1:0] DstAdr = '0;
    logic [AW:0]   Len = '0;
    logic [7:0]    FillVal = '0;
    logic          Busy, Done, Err, ReadEn, WriteEn;
    logic [7:0]    Result, DatIn, DatOut;
    logic [AW-1:0] MemAdr;

    dm_copy_engine #(.AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .Start(Start), .Op(Op), .SrcAdr(SrcAdr), .DstAdr(DstAdr),
        .Len(Len), .FillVal(FillVal), .Busy(Busy), .Done(Done), .Err(Err), .Result(Result),
        .MemAdr(MemAdr), .ReadEn(ReadEn), .WriteEn(WriteEn), .DatIn(DatIn), .DatOut(DatOut)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [256];
    logic [7:0] ref_mem [256];

    assign DatOut = ReadEn ? mem[MemAdr] : 8'hzz;
    always @(posedge clk) if (WriteEn) mem[MemAdr] <= DatIn;

    int checks = 0;
    int errors = 0;
    int wr_cycles = 0;
    int rd_cycles = 0;
    int both_cnt = 0;
    logic [15:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (ReadEn && WriteEn) both_cnt++;
        if (ReadEn) rd_cycles++;
        if (WriteEn) begin
            wr_cycles++;
            if (exp_q.size() == 0) check("wr_extra", 32'd1, 32'd0);
            else check("wr_adr_dat", {16'd0, MemAdr, DatIn}, {16'd0, exp_q.pop_front()});
        end
    end

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        mem[a] = d;
        ref_mem[a] = d;
    endtask

    task automatic mem_compare(input string tag);
        int bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
        check(tag, bad, 0);
    endtask

    // Called at a negedge with the engine idle.
    task automatic run_cmd(input logic [1:0] op, input logic [7:0] src, input logic [7:0] dst,
                           input logic [8:0] len, input logic [7:0] fill, input logic hold);
        logic [7:0] sa, da, sum;
        int exp_lat, exp_wr, exp_rd, cyc;
        sum = 8'd0;
        for (int i = 0; i < int'(len) && op != 2'b11; i++) begin
            sa = src + 8'(i);
            da = dst + 8'(i);
            if (op == 2'b00) begin
                ref_mem[da] = ref_mem[sa];
                exp_q.push_back({da, ref_mem[da]});
            end else if (op == 2'b01) begin
                ref_mem[da] = fill;
                exp_q.push_back({da, fill});
            end else if (op == 2'b10) begin
                sum = sum + ref_mem[sa];
            end
        end
        if (op == 2'b11 || len == 0) exp_lat = 1;
        else if (op == 2'b00)        exp_lat = 2 * int'(len) + 1;
        else                         exp_lat = int'(len) + 1;
        exp_wr = (op == 2'b00 || op == 2'b01) ? int'(len) : 0;
        exp_rd = (op == 2'b00 || op == 2'b10) ? int'(len) : 0;
        if (op == 2'b11) begin exp_wr = 0; exp_rd = 0; end

        wr_cycles = 0;
        rd_cycles = 0;
        Start = 1'b1; Op = op; SrcAdr = src; DstAdr = dst; Len = len; FillVal = fill;
        @(posedge clk);
        #1;
        // Scramble the command inputs; the engine must work from its latched copy.
        Op = 2'b11; SrcAdr = ~src; DstAdr = ~dst; Len = 9'd0; FillVal = ~fill;
        if (!hold) Start = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!Done && cyc < 3000);
        Start = 1'b0;
        check("done_lat", cyc, exp_lat);
        check("err", {31'd0, Err}, {31'd0, op == 2'b11});
        check("busy_in_done", {31'd0, Busy}, 32'd1);
        @(negedge clk);
        check("busy_idle", {31'd0, Busy}, 32'd0);
        check("done_pulse", {31'd0, Done}, 32'd0);
        if (op == 2'b10) check("result", {24'd0, Result}, {24'd0, sum});
        check("wr_cycles", wr_cycles, exp_wr);
        check("rd_cycles", rd_cycles, exp_rd);
        check("q_empty", exp_q.size(), 0);
        exp_q.delete();
        mem_compare("mem");
    endtask

    initial begin
        logic [1:0] rop;
        logic [8:0] rlen;
        for (int i = 0; i < 256; i++) preload(8'(i), 8'($urandom_range(0, 255)));

        repeat (2) @(negedge clk);
        check("rst_outs", {23'd0, Busy, Done, Err, ReadEn, WriteEn, MemAdr != 0, DatIn != 0, Result != 0},
              32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", {31'd0, Busy}, 32'd0);

        // Copy of three bytes.
        preload(8'h10, 8'hA1); preload(8'h11, 8'hB2); preload(8'h12, 8'hC3);
        run_cmd(2'b00, 8'h10, 8'h40, 9'd3, 8'h00, 1'b0);
        // Fill across the top-of-memory wrap.
        run_cmd(2'b01, 8'h00, 8'hFE, 9'd4, 8'h5A, 1'b0);
        // Sum with carries discarded.
        preload(8'h20, 8'hFF); preload(8'h21, 8'hFF); preload(8'h22, 8'h03); preload(8'h23, 8'h01);
        run_cmd(2'b10, 8'h20, 8'h00, 9'd4, 8'h00, 1'b0);
        check("result_hold", {24'd0, Result}, 32'h02);
        // Zero length, illegal op, and Start held high through a busy fill.
        run_cmd(2'b00, 8'h10, 8'h50, 9'd0, 8'h00, 1'b0);
        run_cmd(2'b11, 8'h10, 8'h50, 9'd5, 8'h00, 1'b0);
        run_cmd(2'b01, 8'h00, 8'h70, 9'd4, 8'h3C, 1'b1);
        check("result_kept", {24'd0, Result}, 32'h02);
        // Back-to-back sum of zero length clears Result.
        run_cmd(2'b10, 8'h20, 8'h00, 9'd0, 8'h00, 1'b0);
        check("result_len0", {24'd0, Result}, 32'h00);

        // Random commands.
        for (int t = 0; t < 4; t++) begin
            rop  = 2'($urandom_range(0, 2));
            rlen = 9'($urandom_range(1, 20));
            run_cmd(rop, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), rlen,
                    8'($urandom_range(0, 255)), 1'b0);
        end

        // Full-memory overlapping copy.
        for (int i = 0; i < 256; i++) preload(8'(i), 8'(i));
        run_cmd(2'b00, 8'h00, 8'h80, 9'h100, 8'h00, 1'b0);

        // Reset during the second write of a copy.
        preload(8'h30, 8'hA1); preload(8'h31, 8'hB2); preload(8'h32, 8'hC3);
        preload(8'h60, 8'h00); preload(8'h61, 8'h00); preload(8'h62, 8'h00);
        exp_q.push_back({8'h60, 8'hA1});
        exp_q.push_back({8'h61, 8'hB2});
        ref_mem[8'h60] = 8'hA1;
        Start = 1'b1; Op = 2'b00; SrcAdr = 8'h30; DstAdr = 8'h60; Len = 9'd3;
        @(posedge clk);
        #1 Start = 1'b0;
        repeat (4) @(negedge clk);
        check("wr2_active", {24'd0, WriteEn, MemAdr[6:0]}, {24'd0, 1'b1, 7'h61});
        #1 rst_n = 1'b0;
        #1;
        check("rst_busy", {31'd0, Busy}, 32'd0);
        check("rst_wen", {31'd0, WriteEn}, 32'd0);
        check("rst_ren", {31'd0, ReadEn}, 32'd0);
        check("rst_adr", {24'd0, MemAdr}, 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mem_compare("mem_after_rst");
        run_cmd(2'b01, 8'h00, 8'h90, 9'd2, 8'hE7, 1'b0);

        check("rd_wr_exclusive", both_cnt, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
